// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding types for the program loader: opcode enum, funct3 type,
// field record struct and loader FSM states.
package rv32i_pkg;

    localparam int DPW = 32;

    typedef enum logic [6:0] {
        R_TYPE = 7'b0110011,
        OP_IMM = 7'b0010011,
        LOAD   = 7'b0000011,
        S_TYPE = 7'b0100011,
        B_TYPE = 7'b1100011,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111
    } instr_type_t;

    typedef logic [2:0] func_code_t;

    typedef struct packed {
        instr_type_t    instr_type;
        func_code_t     func_code;
        logic           funct7b5;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [4:0]     rd;
        logic [DPW-1:0] imm;
    } fld_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE
    } load_state_t;

    // SLLI/SRLI/SRAI carry funct7 in the upper immediate bits.
    function automatic logic is_shift_imm(input func_code_t f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/instr_encode_loader_if.sv
// Field-record handshake plus the imem write bus of the program loader.
interface instr_encode_loader_if #(parameter int AW = 8);
    import rv32i_pkg::*;

    logic           fld_valid;
    logic           fld_ready;
    logic           fld_last;
    instr_type_t    instr_type;
    func_code_t     func_code;
    logic           funct7b5;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [4:0]     rd;
    logic [DPW-1:0] imm;

    logic           imem_we;
    logic [AW-1:0]  imem_addr;
    logic [DPW-1:0] imem_wdata;

    modport master (
        output fld_valid, fld_last, instr_type, func_code, funct7b5, rs1, rs2, rd, imm,
        input  fld_ready,
        input  imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  fld_valid, fld_last, instr_type, func_code, funct7b5, rs1, rs2, rd, imm,
        output fld_ready,
        output imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/instr_packer.sv
// Combinational RV32I field packer: builds the instruction word for one record
// and flags whether its opcode is a known format.
module instr_packer
    import rv32i_pkg::*;
(
    input  fld_rec_t       rec,
    output logic [DPW-1:0] word,
    output logic           legal
);

    logic [6:0] op;

    assign op = rec.instr_type;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (rec.instr_type)
            R_TYPE: begin
                word = {1'b0, rec.funct7b5, 5'b0, rec.rs2, rec.rs1, rec.func_code, rec.rd, op};
            end
            OP_IMM, LOAD, JALR: begin
                word = {rec.imm[11:0], rec.rs1, rec.func_code, rec.rd, op};
                if (rec.instr_type == OP_IMM && is_shift_imm(rec.func_code)) begin
                    word[31:25] = {1'b0, rec.funct7b5, 5'b0};
                end
            end
            S_TYPE: begin
                word = {rec.imm[11:5], rec.rs2, rec.rs1, rec.func_code, rec.imm[4:0], op};
            end
            B_TYPE: begin
                word = {rec.imm[12], rec.imm[10:5], rec.rs2, rec.rs1, rec.func_code,
                        rec.imm[4:1], rec.imm[11], op};
            end
            LUI, AUIPC: begin
                word = {rec.imm[31:12], rec.rd, op};
            end
            JAL: begin
                word = {rec.imm[20], rec.imm[10:1], rec.imm[11], rec.imm[19:12], rec.rd, op};
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: accepts decoded field records, packs each into an RV32I word
// and writes it to imem at an auto-incrementing address, one word per 2 cycles.
module instr_encode_loader
    import rv32i_pkg::*;
#(
    parameter int AW   = 8,
    parameter int BASE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    instr_encode_loader_if.slave  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err_illegal,
    output logic                  err_ovf,
    output logic [AW:0]           wr_count
);

    localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
    localparam logic [AW-1:0] LAST_ADDR = '1;

    load_state_t    state_reg, state_next;
    logic [AW-1:0]  addr_reg;
    logic [DPW-1:0] hold_reg;
    logic           last_reg;
    logic [AW:0]    wr_count_reg;
    logic           err_illegal_reg;
    logic           err_ovf_reg;

    fld_rec_t       rec;
    logic [DPW-1:0] packed_word;
    logic           packed_legal;
    logic           accept_hs;

    assign rec = '{
        instr_type: bus.instr_type,
        func_code:  bus.func_code,
        funct7b5:   bus.funct7b5,
        rs1:        bus.rs1,
        rs2:        bus.rs2,
        rd:         bus.rd,
        imm:        bus.imm
    };

    instr_packer u_packer (
        .rec   (rec),
        .word  (packed_word),
        .legal (packed_legal)
    );

    assign accept_hs = (state_reg == ST_ACCEPT) && bus.fld_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (bus.fld_valid) begin
                    if (packed_legal) begin
                        state_next = ST_WRITE;
                    end else if (bus.fld_last) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                // Memory is never wrapped: a full imem ends the session early.
                if (last_reg || addr_reg == LAST_ADDR) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_ACCEPT;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // imem_we is decoded from state, so the async reset drops it immediately.
    always_comb begin
        bus.fld_ready = (state_reg == ST_ACCEPT);
        bus.imem_we   = (state_reg == ST_WRITE);
        busy          = (state_reg != ST_IDLE);
        done          = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg        <= BASE_ADDR;
            hold_reg        <= '0;
            last_reg        <= 1'b0;
            wr_count_reg    <= '0;
            err_illegal_reg <= 1'b0;
            err_ovf_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        addr_reg        <= BASE_ADDR;
                        wr_count_reg    <= '0;
                        err_illegal_reg <= 1'b0;
                        err_ovf_reg     <= 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    if (accept_hs) begin
                        if (packed_legal) begin
                            hold_reg <= packed_word;
                            last_reg <= bus.fld_last;
                        end else begin
                            err_illegal_reg <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    wr_count_reg <= wr_count_reg + 1'b1;
                    if (!last_reg) begin
                        if (addr_reg == LAST_ADDR) begin
                            err_ovf_reg <= 1'b1;
                        end else begin
                            addr_reg <= addr_reg + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.imem_addr  = addr_reg;
    assign bus.imem_wdata = hold_reg;
    assign err_illegal    = err_illegal_reg;
    assign err_ovf        = err_ovf_reg;
    assign wr_count       = wr_count_reg;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: hand-encoded RV32I words, illegal
// records, overflow on a 4-word imem and mid-write reset.
module tb_instr_encode_loader;
    import rv32i_pkg::*;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic valid_a = 1'b0;
    logic valid_b = 1'b0;

    instr_type_t f_type = OP_IMM;
    func_code_t  f_f3   = 3'b000;
    logic        f_f7   = 1'b0;
    logic [4:0]  f_rs1  = '0;
    logic [4:0]  f_rs2  = '0;
    logic [4:0]  f_rd   = '0;
    logic [31:0] f_imm  = '0;
    logic        f_last = 1'b0;

    logic       busy_a, done_a, ill_a, ovf_a;
    logic [8:0] wc_a;
    logic       busy_b, done_b, ill_b, ovf_b;
    logic [2:0] wc_b;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    wr_t wq_a[$];
    int  wq_b[$];
    int  d_wc, d_ill, d_ovf;
    bit  ok, seen;
    int  k;

    instr_encode_loader_if #(.AW(8)) bus_a ();
    instr_encode_loader_if #(.AW(2)) bus_b ();

    assign bus_a.fld_valid  = valid_a;
    assign bus_a.fld_last   = f_last;
    assign bus_a.instr_type = f_type;
    assign bus_a.func_code  = f_f3;
    assign bus_a.funct7b5   = f_f7;
    assign bus_a.rs1        = f_rs1;
    assign bus_a.rs2        = f_rs2;
    assign bus_a.rd         = f_rd;
    assign bus_a.imm        = f_imm;
    assign bus_b.fld_valid  = valid_b;
    assign bus_b.fld_last   = f_last;
    assign bus_b.instr_type = f_type;
    assign bus_b.func_code  = f_f3;
    assign bus_b.funct7b5   = f_f7;
    assign bus_b.rs1        = f_rs1;
    assign bus_b.rs2        = f_rs2;
    assign bus_b.rd         = f_rd;
    assign bus_b.imm        = f_imm;

    instr_encode_loader #(.AW(8), .BASE(0)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .start       (start_a),
        .bus         (bus_a.slave),
        .busy        (busy_a),
        .done        (done_a),
        .err_illegal (ill_a),
        .err_ovf     (ovf_a),
        .wr_count    (wc_a)
    );

    instr_encode_loader #(.AW(2), .BASE(0)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .start       (start_b),
        .bus         (bus_b.slave),
        .busy        (busy_b),
        .done        (done_b),
        .err_illegal (ill_b),
        .err_ovf     (ovf_b),
        .wr_count    (wc_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_a.imem_we) begin
            wq_a.push_back('{addr: int'(bus_a.imem_addr), data: bus_a.imem_wdata, cyc: cyc});
            $display("dut_a write addr=%0d data=0x%08h cycle=%0d", bus_a.imem_addr, bus_a.imem_wdata, cyc);
        end
        if (bus_b.imem_we) begin
            wq_b.push_back(int'(bus_b.imem_addr));
            $display("dut_b write addr=%0d data=0x%08h cycle=%0d", bus_b.imem_addr, bus_b.imem_wdata, cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with valid dropped.
    task automatic send_rec(input bit sel_b, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rdd, input logic [31:0] im, input logic last,
                            output bit acc);
        f_type = instr_type_t'(op);
        f_f3   = f3;
        f_f7   = f7;
        f_rs1  = r1;
        f_rs2  = r2;
        f_rd   = rdd;
        f_imm  = im;
        f_last = last;
        if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 12 && !acc; i++) begin
            if (sel_b ? bus_b.fld_ready : bus_a.fld_ready) begin
                @(posedge clk);
                acc = 1'b1;
            end
            @(negedge clk);
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic start_sess(input bit sel_b);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel_b, output bit got_done);
        got_done = 1'b0;
        for (int i = 0; i < 30 && !got_done; i++) begin
            if (sel_b ? done_b : done_a) begin
                got_done = 1'b1;
                d_wc  = sel_b ? int'(wc_b) : int'(wc_a);
                d_ill = sel_b ? int'(ill_b) : int'(ill_a);
                d_ovf = sel_b ? int'(ovf_b) : int'(ovf_a);
            end
            @(negedge clk);
        end
        check("done_seen", got_done, 1'b1);
        check("done_one_cycle", sel_b ? done_b : done_a, 1'b0);
        check("idle_after_done", sel_b ? busy_b : busy_a, 1'b0);
    endtask

    task automatic check_w(input string tag, input int idx, input int addr, input logic [31:0] data);
        if (idx < wq_a.size()) begin
            check({tag, "_addr"}, wq_a[idx].addr, addr);
            check({tag, "_data"}, wq_a[idx].data, data);
        end else begin
            check({tag, "_present"}, wq_a.size(), idx + 1);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", bus_a.fld_ready, 1'b0);
        check("rst_we", bus_a.imem_we, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_ill", ill_a, 1'b0);
        check("rst_ovf", ovf_a, 1'b0);
        check("rst_addr", bus_a.imem_addr, 32'd0);
        check("rst_wdata", bus_a.imem_wdata, 32'd0);
        check("rst_wc", wc_a, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // start together with a valid record: only start acts in IDLE
        f_type = OP_IMM; f_f3 = 3'b000; f_rs1 = 5'd0; f_rd = 5'd1; f_imm = 32'd5; f_last = 1'b1;
        valid_a = 1'b1;
        k = cyc;
        start_sess(1'b0);
        send_rec(1'b0, 7'b0010011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, ok);
        check("s1_accept", ok, 1'b1);
        wait_done(1'b0, seen);
        check("s1_nwrites", wq_a.size(), 32'd1);
        check_w("s1_addi", 0, 0, 32'h00500093);
        if (wq_a.size() > 0) check("s1_latency", wq_a[0].cyc, k + 2);
        check("s1_wc", d_wc, 32'd1);
        wq_a.delete();

        // R-type pair, shift-immediate, negative addi
        start_sess(1'b0);
        send_rec(1'b0, 7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, ok);
        send_rec(1'b0, 7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, ok);
        send_rec(1'b0, 7'b0010011, 3'b101, 1'b1, 5'd6, 5'd0, 5'd5, 32'd4, 1'b0, ok);
        send_rec(1'b0, 7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd1, 32'hFFFF_FFFF, 1'b1, ok);
        wait_done(1'b0, seen);
        check("s2_nwrites", wq_a.size(), 32'd4);
        check_w("s2_add", 0, 0, 32'h002081B3);
        check_w("s2_sub", 1, 1, 32'h402081B3);
        check_w("s2_srai", 2, 2, 32'h40435293);
        check_w("s2_addi_neg", 3, 3, 32'hFFF08093);
        if (wq_a.size() > 1) check("s2_spacing", wq_a[1].cyc - wq_a[0].cyc, 32'd2);
        check("s2_wc", d_wc, 32'd4);
        wq_a.delete();

        // S, B, J, U formats
        start_sess(1'b0);
        send_rec(1'b0, 7'b0100011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0, ok);
        send_rec(1'b0, 7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0, ok);
        send_rec(1'b0, 7'b1101111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd16, 1'b0, ok);
        send_rec(1'b0, 7'b0110111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b1, ok);
        wait_done(1'b0, seen);
        check_w("s3_sw", 0, 0, 32'h0020A423);
        check_w("s3_beq", 1, 1, 32'h00208463);
        check_w("s3_jal", 2, 2, 32'h010000EF);
        check_w("s3_lui", 3, 3, 32'h123452B7);
        check("s3_wc", d_wc, 32'd4);
        check("s3_ill", d_ill, 32'd0);
        wq_a.delete();

        // illegal opcode between two legal records
        start_sess(1'b0);
        send_rec(1'b0, 7'b0010011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0, ok);
        send_rec(1'b0, 7'b1111111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0, ok);
        check("s4_illegal_taken", ok, 1'b1);
        send_rec(1'b0, 7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, ok);
        wait_done(1'b0, seen);
        check("s4_nwrites", wq_a.size(), 32'd2);
        check_w("s4_first", 0, 0, 32'h00500093);
        check_w("s4_second", 1, 1, 32'h002081B3);
        check("s4_ill", d_ill, 32'd1);
        check("s4_wc", d_wc, 32'd2);
        check("s4_ill_sticky", ill_a, 1'b1);
        wq_a.delete();

        // illegal record carrying last ends the session with no write
        start_sess(1'b0);
        check("s5_ill_cleared", ill_a, 1'b0);
        send_rec(1'b0, 7'b1111111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, ok);
        wait_done(1'b0, seen);
        check("s5_nwrites", wq_a.size(), 32'd0);
        check("s5_wc", d_wc, 32'd0);
        check("s5_ill", d_ill, 32'd1);
        wq_a.delete();

        // reset during a WRITE cycle
        start_sess(1'b0);
        send_rec(1'b0, 7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, ok);
        send_rec(1'b0, 7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, ok);
        send_rec(1'b0, 7'b0100011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0, ok);
        check("s6_in_write", bus_a.imem_we, 1'b1);
        check("s6_write_addr", bus_a.imem_addr, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("s6_rst_we", bus_a.imem_we, 1'b0);
        check("s6_rst_busy", busy_a, 1'b0);
        check("s6_rst_ready", bus_a.fld_ready, 1'b0);
        check("s6_rst_addr", bus_a.imem_addr, 32'd0);
        check("s6_rst_wdata", bus_a.imem_wdata, 32'd0);
        check("s6_rst_wc", wc_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wq_a.delete();
        start_sess(1'b0);
        send_rec(1'b0, 7'b0110111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b1, ok);
        wait_done(1'b0, seen);
        check_w("s6_restart", 0, 0, 32'h123452B7);
        check("s6_wc", d_wc, 32'd1);

        // 4-word imem: overflow ends the session, fifth record refused
        start_sess(1'b1);
        for (int i = 0; i < 4; i++) begin
            send_rec(1'b1, 7'b0010011, 3'b000, 1'b0, 5'd0, 5'd0, 5'(i + 1), i, 1'b0, ok);
            check("ovf_accept", ok, 1'b1);
        end
        wait_done(1'b1, seen);
        check("ovf_flag", d_ovf, 32'd1);
        check("ovf_wc", d_wc, 32'd4);
        send_rec(1'b1, 7'b0010011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd5, 32'd5, 1'b0, ok);
        check("ovf_fifth_refused", ok, 1'b0);
        check("ovf_nwrites", wq_b.size(), 32'd4);
        for (int i = 0; i < 4 && i < wq_b.size(); i++) begin
            check("ovf_addr", wq_b[i], i);
        end
        check("ovf_sticky", ovf_b, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
# instr_encode_loader

- Assembles RV32I instruction words from decoded fields and writes them sequentially into instruction memory.
- Performs the inverse of instruction-field decode: each accepted field record is packed into a 32-bit word per its format (R/I/S/B/U/J), then written at an auto-incrementing word address.
- Used by the test/boot path to load programs into the imem of the rv32i core without a hex file.

## Interface

Parameters:
- AW, 8: imem word-address width; capacity 2**AW words.
- BASE, 0: first word address written after `start`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load session; sampled only in IDLE.
- fld_valid  in  1  field record valid.
- fld_ready  out  1  record accepted when fld_valid && fld_ready.
- fld_last  in  1  record is the final instruction of the session.
- instr_type  in  instr_type_t  opcode field (bits 6:0).
- func_code  in  func_code_t  funct3.
- funct7b5  in  1  instruction bit 30 for R-type and shift-immediate.
- rs1, rs2, rd  in  5 each  register addresses.
- imm  in  DPW (32)  sign-extended immediate value, before scrambling.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  AW  word address.
- imem_wdata  out  DPW  encoded instruction.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- err_illegal  out  1  sticky; an unknown opcode record was dropped.
- err_ovf  out  1  sticky; memory filled before fld_last.
- wr_count  out  AW+1  words written this session.

## Operation

- FSM states are IDLE, ACCEPT, WRITE, and DONE.
- **IDLE**
  - On start: addr←BASE, wr_count←0, both error flags cleared, go to ACCEPT.
- **ACCEPT**
  - fld_ready=1.
  - On handshake: encode into the holding register, latch fld_last, go to WRITE.
  - If the opcode is not a legal instr_type_t member: set err_illegal, no write, stay in ACCEPT.
  - If that dropped record had fld_last set: go to DONE.
- **WRITE**
  - Assert imem_we=1 with the holding register and addr; wr_count+1.
  - Next state:
    - latched last → DONE;
    - else addr==2**AW-1 → set err_ovf, go to DONE (no wrap);
    - else addr+1, go to ACCEPT.
- **DONE**
  - done=1 for one cycle, then go to IDLE.
- busy=1 in every state except IDLE.
- start outside IDLE is ignored.
- Encoding (opcode = instr_type; funct3 occupies 14:12 where present):
  - R: {0,funct7b5,00000, rs2, rs1, f3, rd, op}.
  - I (OP_IMM, LOAD, JALR): {imm[11:0], rs1, f3, rd, op}.
    - For OP_IMM shifts (f3=001/101), bits 31:25 = {0,funct7b5,00000}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U (LUI, AUIPC): {imm[31:12], rd, op}.
  - J (JAL): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Unused immediate bits are ignored without error: imm[0] for B/J, upper bits for I/S.

## Timing

- Record accepted at edge N: imem_we/addr/wdata are valid during cycle N+1.
- Throughput is one word per 2 cycles.
- The record must remain stable only in the handshake cycle.
- After the final write in cycle N+1, done pulses in cycle N+2, and fld_ready returns after IDLE→start.
- Reset values:
  - state=IDLE;
  - fld_ready, imem_we, busy, done, err_illegal, err_ovf = 0;
  - imem_addr=BASE; imem_wdata=0; wr_count=0.
- Reset asserted mid-session aborts immediately. A write in progress in the reset cycle is suppressed (imem_we forced 0 asynchronously).
- start and fld_valid asserted in the same IDLE cycle: only start is acted on; the record is taken in ACCEPT on the next cycle.

## Structure

- rv32i_pkg holds:
  - instr_type_t with members R_TYPE 0110011, OP_IMM 0010011, LOAD 0000011, S_TYPE 0100011, B_TYPE 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111;
  - func_code_t;
  - DPW=32.
- One combinational sub-module, instr_packer: fields in, 32-bit word plus a legal flag out.
  - Reusable by the bench as a reference model.
- The FSM, address counter and holding register live in instr_encode_loader.

## Test plan

- AW=8, BASE=0: start, then addi x1,x0,5 (OP_IMM, f3=0, rd=1, imm=5) → imem_we at addr 0 with 0x00500093.
- add x3,x1,x2 followed by the same with funct7b5=1 → 0x002081B3 at addr 0, 0x402081B3 at addr 1, 2 cycles apart.
- sw x2,8(x1) → 0x0020A423; beq x1,x2,+8 → 0x00208463; jal x1,+16 → 0x010000EF; lui x5 imm=0x12345000 with fld_last → 0x123452B7, then a done pulse with wr_count=4.
- Opcode 7'b1111111 between two legal records:
  - no write for the illegal record; err_illegal=1;
  - the surrounding words land at consecutive addrs 0, 1.
- AW=2: five records with no last → four writes at addrs 0..3, err_ovf=1, done, fifth record never accepted.
- rst pulsed in the WRITE cycle → imem_we drops in the same cycle; all outputs at reset values; the next start writes from BASE.
